// File: rtl/gfau_point_sequencer.sv
// Affine ECC point add/double sequencer: walks a micro-op ROM, issuing each op to
// an external GFAU over a start/done handshake and writing results to scratch registers.
module gfau_point_sequencer #(
    parameter int SIZE      = 32,
    parameter int TEMP_REGS = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            start,
    input  logic            is_double,
    input  logic            p_inf,
    input  logic            q_inf,
    input  logic [SIZE-1:0] x1,
    input  logic [SIZE-1:0] y1,
    input  logic [SIZE-1:0] x2,
    input  logic [SIZE-1:0] y2,
    input  logic [SIZE-1:0] a,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] r_x,
    output logic [SIZE-1:0] r_y,
    output logic            r_inf,
    output logic [1:0]      operation_select,
    output logic [SIZE-1:0] gfau_in_0,
    output logic [SIZE-1:0] gfau_in_1,
    output logic            gfau_start,
    input  logic            gfau_done,
    input  logic [SIZE-1:0] gfau_result
);

    localparam int NREGS = 7 + TEMP_REGS;

    localparam logic [3:0] R_X1 = 4'd0;
    localparam logic [3:0] R_Y1 = 4'd1;
    localparam logic [3:0] R_X2 = 4'd2;
    localparam logic [3:0] R_Y2 = 4'd3;
    localparam logic [3:0] R_A  = 4'd4;
    localparam logic [3:0] R_T0 = 4'd5;
    localparam logic [3:0] R_T1 = 4'd6;
    localparam logic [3:0] R_T2 = 4'd7;
    localparam logic [3:0] R_T3 = 4'd8;
    localparam logic [3:0] R_L  = 4'd9;
    localparam logic [3:0] R_X3 = 4'(5 + TEMP_REGS);
    localparam logic [3:0] R_Y3 = 4'(6 + TEMP_REGS);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;

    localparam logic [4:0] ADD_FIRST = 5'd0;
    localparam logic [4:0] ADD_LAST  = 5'd9;
    localparam logic [4:0] DBL_FIRST = 5'd10;
    localparam logic [4:0] DBL_LAST  = 5'd22;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_P    = 2'd1;
    localparam logic [1:0] SRC_Q    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_FIN
    } state_t;

    // ROM word = {op, dst, src0, src1}; add sequence at 0..9, double at 10..22.
    function automatic logic [13:0] rom_word(input logic [4:0] idx);
        logic [13:0] w;
        w = '0;
        case (idx)
            5'd0:  w = {OP_SUB, R_T0, R_Y2, R_Y1};
            5'd1:  w = {OP_SUB, R_T1, R_X2, R_X1};
            5'd2:  w = {OP_INV, R_T1, R_T1, 4'd0};
            5'd3:  w = {OP_MUL, R_L,  R_T0, R_T1};
            5'd4:  w = {OP_MUL, R_T2, R_L,  R_L };
            5'd5:  w = {OP_SUB, R_T2, R_T2, R_X1};
            5'd6:  w = {OP_SUB, R_X3, R_T2, R_X2};
            5'd7:  w = {OP_SUB, R_T3, R_X1, R_X3};
            5'd8:  w = {OP_MUL, R_T3, R_L,  R_T3};
            5'd9:  w = {OP_SUB, R_Y3, R_T3, R_Y1};
            5'd10: w = {OP_MUL, R_T0, R_X1, R_X1};
            5'd11: w = {OP_ADD, R_T1, R_T0, R_T0};
            5'd12: w = {OP_ADD, R_T0, R_T1, R_T0};
            5'd13: w = {OP_ADD, R_T0, R_T0, R_A };
            5'd14: w = {OP_ADD, R_T1, R_Y1, R_Y1};
            5'd15: w = {OP_INV, R_T1, R_T1, 4'd0};
            5'd16: w = {OP_MUL, R_L,  R_T0, R_T1};
            5'd17: w = {OP_MUL, R_T2, R_L,  R_L };
            5'd18: w = {OP_ADD, R_T3, R_X1, R_X1};
            5'd19: w = {OP_SUB, R_X3, R_T2, R_T3};
            5'd20: w = {OP_SUB, R_T3, R_X1, R_X3};
            5'd21: w = {OP_MUL, R_T3, R_L,  R_T3};
            5'd22: w = {OP_SUB, R_Y3, R_T3, R_Y1};
            default: w = '0;
        endcase
        return w;
    endfunction

    state_t          state, state_n;
    logic [4:0]      op_idx, op_idx_n;
    logic            req_dbl, req_pinf, req_qinf;
    logic            fin_inf;
    logic            chk_fin, chk_inf;
    logic [1:0]      chk_src;
    logic [3:0]      wb_dst;
    logic [SIZE-1:0] res_q;
    logic [SIZE-1:0] regs [NREGS];

    logic [13:0]     rom_nxt;
    logic [1:0]      nxt_op;
    logic [3:0]      nxt_dst, nxt_src0, nxt_src1;
    logic [SIZE-1:0] opnd_0, opnd_1;

    assign rom_nxt = rom_word(op_idx_n);
    assign {nxt_op, nxt_dst, nxt_src0, nxt_src1} = rom_nxt;

    // The register written in WB is not yet visible to the op issued on the same edge.
    always_comb begin
        opnd_0 = regs[nxt_src0];
        opnd_1 = regs[nxt_src1];
        if (state == S_WB && nxt_src0 == wb_dst) opnd_0 = res_q;
        if (state == S_WB && nxt_src1 == wb_dst) opnd_1 = res_q;
        if (nxt_op == OP_INV) opnd_1 = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        op_idx_n = op_idx;
        chk_fin  = 1'b0;
        chk_inf  = 1'b0;
        chk_src  = SRC_NONE;
        case (state)
            S_IDLE: if (start) state_n = S_CHECK;
            S_CHECK: begin
                if (req_dbl) begin
                    if (req_pinf || regs[R_Y1] == '0) begin
                        chk_fin = 1'b1;
                        chk_inf = 1'b1;
                    end else begin
                        op_idx_n = DBL_FIRST;
                    end
                end else if (req_pinf) begin
                    chk_fin = 1'b1;
                    chk_inf = req_qinf;
                    chk_src = SRC_Q;
                end else if (req_qinf) begin
                    chk_fin = 1'b1;
                    chk_src = SRC_P;
                end else if (regs[R_X1] == regs[R_X2]) begin
                    // Equal points double; P + (-P), or doubling a y=0 point, is infinity.
                    if (regs[R_Y1] == regs[R_Y2] && regs[R_Y1] != '0) begin
                        op_idx_n = DBL_FIRST;
                    end else begin
                        chk_fin = 1'b1;
                        chk_inf = 1'b1;
                    end
                end else begin
                    op_idx_n = ADD_FIRST;
                end
                state_n = chk_fin ? S_FIN : S_ISSUE;
            end
            S_ISSUE: state_n = S_WAIT;
            S_WAIT:  if (gfau_done) state_n = S_WB;
            S_WB: begin
                if (op_idx == ADD_LAST || op_idx == DBL_LAST) begin
                    state_n = S_FIN;
                end else begin
                    op_idx_n = op_idx + 5'd1;
                    state_n  = S_ISSUE;
                end
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            gfau_start       <= 1'b0;
            r_inf            <= 1'b0;
            r_x              <= '0;
            r_y              <= '0;
            operation_select <= 2'b00;
            gfau_in_0        <= '0;
            gfau_in_1        <= '0;
            op_idx           <= 5'd0;
            req_dbl          <= 1'b0;
            req_pinf         <= 1'b0;
            req_qinf         <= 1'b0;
            fin_inf          <= 1'b0;
            wb_dst           <= 4'd0;
        end else begin
            done       <= 1'b0;
            gfau_start <= 1'b0;
            op_idx     <= op_idx_n;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        req_dbl  <= is_double;
                        req_pinf <= p_inf;
                        req_qinf <= q_inf;
                    end
                end
                S_CHECK: fin_inf <= chk_fin & chk_inf;
                S_FIN: begin
                    r_x   <= fin_inf ? '0 : regs[R_X3];
                    r_y   <= fin_inf ? '0 : regs[R_Y3];
                    r_inf <= fin_inf;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
            // Operands are registered once per op and held through WAIT.
            if (state_n == S_ISSUE) begin
                operation_select <= nxt_op;
                gfau_in_0        <= opnd_0;
                gfau_in_1        <= opnd_1;
                gfau_start       <= 1'b1;
                wb_dst           <= nxt_dst;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        case (state)
            S_IDLE: begin
                if (start) begin
                    regs[R_X1] <= x1;
                    regs[R_Y1] <= y1;
                    regs[R_X2] <= x2;
                    regs[R_Y2] <= y2;
                    regs[R_A]  <= a;
                end
            end
            S_CHECK: begin
                if (chk_src == SRC_Q) begin
                    regs[R_X3] <= regs[R_X2];
                    regs[R_Y3] <= regs[R_Y2];
                end else if (chk_src == SRC_P) begin
                    regs[R_X3] <= regs[R_X1];
                    regs[R_Y3] <= regs[R_Y1];
                end
            end
            S_WAIT: if (gfau_done) res_q <= gfau_result;
            S_WB:   regs[wb_dst] <= res_q;
            default: ;
        endcase
    end

endmodule
